// File: rtl/video_fetch_pkg.sv
// video_fetch_pkg: shared types and widths for the video line fetch controller.
package video_fetch_pkg;
   typedef enum logic [2:0] {IDLE, ARM, CHK, REQ, WAIT} fetch_state_t;
   localparam int CREDIT_W = 3;
   localparam int STAT_W = 16;
endpackage

// File: rtl/video_edge_det.sv
// video_edge_det: rise/fall pulses of a same-domain level, derived from one register stage.
module video_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic sig,
   output logic rise,
   output logic fall
);
   logic q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q <= 1'b0;
      else q <= sig;
   end
   assign rise = sig & ~q;
   assign fall = ~sig & q;
endmodule

// File: rtl/video_line_fetch_ctrl.sv
// video_line_fetch_ctrl: prefetches display lines from DDR in bursts, bounded by line-FIFO credit.
// Status counters are built only when FETCH_STATUS_EN is defined.
module video_line_fetch_ctrl
   import video_fetch_pkg::*;
#(
   parameter int V_ACTIVE        = 1080,
   parameter int BURSTS_PER_LINE = 8,
   parameter int BURST_BYTES     = 960,
   parameter int LINE_STRIDE     = 7680,
   parameter int LINE_BUF        = 2,
   parameter int ADDR_W          = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_vs,
   input  logic              i_de,
   input  logic [ADDR_W-1:0] frame_base,
   output logic              rd_req,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic              rd_ack,
   input  logic              rd_done,
   output logic              buf_flush,
   output logic              underflow,
   output logic [STAT_W-1:0] stat_uf_cnt,
   output logic [STAT_W-1:0] stat_frm_cnt
);
   localparam int LINE_W  = $clog2(V_ACTIVE + 1);
   localparam int BURST_W = $clog2(BURSTS_PER_LINE + 1);
   fetch_state_t state, nxt;
   logic vs_rise, vs_fall_unused, de_rise, de_fall;
   logic restart_pend, wrap, adv, inc, can_req, uf_evt;
   logic [ADDR_W-1:0] base, line_off, burst_off;
   logic [LINE_W-1:0] line;
   logic [BURST_W-1:0] burst;
   logic [CREDIT_W-1:0] credit, credit_nxt;
   video_edge_det u_vs (.clk, .rst_n, .sig(i_vs), .rise(vs_rise), .fall(vs_fall_unused));
   video_edge_det u_de (.clk, .rst_n, .sig(i_de), .rise(de_rise), .fall(de_fall));
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = vs_rise ? ARM : IDLE;
         ARM:     nxt = CHK;
         CHK:     nxt = vs_rise ? ARM : can_req ? REQ : CHK;
         REQ:     nxt = rd_ack ? WAIT : REQ;
         WAIT:    nxt = !rd_done ? WAIT : (restart_pend || vs_rise) ? ARM : CHK;
         default: nxt = IDLE;
      endcase
   end
   assign can_req = line < LINE_W'(V_ACTIVE) && credit < CREDIT_W'(LINE_BUF);
   assign adv     = state == WAIT && nxt == CHK;
   assign wrap    = burst == BURST_W'(BURSTS_PER_LINE - 1);
   assign inc     = adv && wrap;
   assign uf_evt  = de_rise && credit == '0;
   // a line completing in the same cycle a line is consumed leaves credit unchanged
   assign credit_nxt = (inc && !de_fall && credit < CREDIT_W'(LINE_BUF)) ? credit + CREDIT_W'(1)
                     : (!inc && de_fall && credit != '0) ? credit - CREDIT_W'(1) : credit;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         restart_pend <= 1'b0;
         underflow    <= 1'b0;
         base         <= '0;
         line_off     <= '0;
         burst_off    <= '0;
         line         <= '0;
         burst        <= '0;
         credit       <= '0;
      end else begin
         state        <= nxt;
         restart_pend <= state != ARM && (restart_pend || (vs_rise && (state == REQ || state == WAIT)));
         underflow    <= uf_evt || (underflow && !vs_rise && state != ARM);
         if (state == ARM) begin
            base      <= frame_base;
            line_off  <= '0;
            burst_off <= '0;
            line      <= '0;
            burst     <= '0;
            credit    <= '0;
         end else begin
            credit <= credit_nxt;
            if (adv) begin
               burst     <= wrap ? '0 : burst + BURST_W'(1);
               burst_off <= wrap ? '0 : burst_off + ADDR_W'(BURST_BYTES);
               if (wrap && line < LINE_W'(V_ACTIVE)) begin
                  line     <= line + LINE_W'(1);
                  line_off <= line_off + ADDR_W'(LINE_STRIDE);
               end
            end
         end
      end
   end
   assign rd_req    = state == REQ;
   assign buf_flush = state == ARM;
   assign rd_addr   = base + line_off + burst_off;
`ifdef FETCH_STATUS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_uf_cnt  <= '0;
         stat_frm_cnt <= '0;
      end else begin
         stat_uf_cnt  <= stat_uf_cnt + STAT_W'(uf_evt && stat_uf_cnt != '1);
         stat_frm_cnt <= stat_frm_cnt + STAT_W'(state == ARM);
      end
   end
`else
   assign stat_uf_cnt  = '0;
   assign stat_frm_cnt = '0;
`endif
endmodule
